// File: rtl/note_selector.sv
// Note selector: synchronises and debounces 8 note keys plus octave up/down buttons,
// then registers the frequency (Hz) of the lowest held key in the current octave.
module note_selector #(
   parameter int DEBOUNCE_CYCLES = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  key_in,
   input  logic        oct_up_in,
   input  logic        oct_dn_in,
   output logic [11:0] freq,
   output logic        note_valid,
   output logic        octave
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [9:0]    w_raw;
   logic [9:0]    r_sync1;
   logic [9:0]    r_sync2;
   logic [9:0]    r_stable;
   logic [CW-1:0] r_cnt [10];
   logic [1:0]    r_prev;
   logic          r_octave;
   logic [11:0]   r_freq;
   logic          r_valid;

   logic          w_up_edge;
   logic          w_dn_edge;
   logic          w_any;
   logic [2:0]    w_idx;
   logic [11:0]   w_freq;

   // Bits 7:0 are note keys, bit 8 is octave-up, bit 9 is octave-down.
   assign w_raw = {oct_dn_in, oct_up_in, key_in};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1  <= '0;
         r_sync2  <= '0;
         r_stable <= '0;
         for (int unsigned i = 0; i < 10; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
         for (int unsigned i = 0; i < 10; i++) begin
            if (r_sync2[i] == r_stable[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == CNT_MAX) begin
               r_stable[i] <= r_sync2[i];
               r_cnt[i]    <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + CW'(1);
            end
         end
      end
   end

   assign w_up_edge = r_stable[8] & ~r_prev[0];
   assign w_dn_edge = r_stable[9] & ~r_prev[1];

   // Opposing edges in the same cycle cancel; both directions saturate.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_prev   <= '0;
         r_octave <= 1'b0;
      end else begin
         r_prev <= r_stable[9:8];
         if (w_up_edge && !w_dn_edge) begin
            r_octave <= 1'b1;
         end else if (w_dn_edge && !w_up_edge) begin
            r_octave <= 1'b0;
         end
      end
   end

   always_comb begin
      w_any = 1'b0;
      w_idx = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (r_stable[i] && !w_any) begin
            w_any = 1'b1;
            w_idx = 3'(i);
         end
      end
   end

   always_comb begin
      w_freq = '0;
      if (w_any) begin
         case ({r_octave, w_idx})
            4'b0_000: w_freq = 12'd131;
            4'b0_001: w_freq = 12'd147;
            4'b0_010: w_freq = 12'd165;
            4'b0_011: w_freq = 12'd175;
            4'b0_100: w_freq = 12'd196;
            4'b0_101: w_freq = 12'd220;
            4'b0_110: w_freq = 12'd247;
            4'b0_111: w_freq = 12'd262;
            4'b1_000: w_freq = 12'd262;
            4'b1_001: w_freq = 12'd294;
            4'b1_010: w_freq = 12'd330;
            4'b1_011: w_freq = 12'd349;
            4'b1_100: w_freq = 12'd392;
            4'b1_101: w_freq = 12'd440;
            4'b1_110: w_freq = 12'd494;
            4'b1_111: w_freq = 12'd523;
            default:  w_freq = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_freq  <= '0;
         r_valid <= 1'b0;
      end else begin
         r_freq  <= w_freq;
         r_valid <= w_any;
      end
   end

   assign freq       = r_freq;
   assign note_valid = r_valid;
   assign octave     = r_octave;

endmodule

// File: tb/tb_note_selector.sv
// Bench for note_selector: directed scenarios plus random button activity, every
// cycle compared against a window-based debounce and table-lookup reference model.
module tb_note_selector;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  key_in;
   logic        oct_up;
   logic        oct_dn;
   logic [11:0] freq;
   logic        note_valid;
   logic        octave;

   int n_vec = 0;
   int n_err = 0;

   int LO [8] = '{131, 147, 165, 175, 196, 220, 247, 262};
   int HI [8] = '{262, 294, 330, 349, 392, 440, 494, 523};

   // Reference model state
   logic [9:0]  q_raw [$];
   logic [9:0]  seen_win [$];
   logic [9:0]  m_stable;
   logic [1:0]  m_prev;
   logic        m_oct;
   logic [11:0] m_freq;
   logic        m_valid;

   note_selector #(.DEBOUNCE_CYCLES(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .key_in     (key_in),
      .oct_up_in  (oct_up),
      .oct_dn_in  (oct_dn),
      .freq       (freq),
      .note_valid (note_valid),
      .octave     (octave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // An input level is accepted once the two-cycle-delayed raw input has shown
   // that level for N consecutive edges.
   task automatic model_step(input logic [9:0] raw, input logic r);
      logic [9:0] seen;
      logic [9:0] st;
      logic       up, dn, found, all1, all0;
      int         idx;
      if (r) begin
         m_stable = '0;
         m_prev   = '0;
         m_oct    = 1'b0;
         m_freq   = '0;
         m_valid  = 1'b0;
         q_raw.delete();
         q_raw.push_back('0);
         q_raw.push_back('0);
         seen_win.delete();
         for (int i = 0; i < N; i++) seen_win.push_back('0);
      end else begin
         seen = q_raw.pop_front();
         q_raw.push_back(raw);
         seen_win.push_back(seen);
         if (seen_win.size() > N) void'(seen_win.pop_front());
         st    = m_stable;
         found = 1'b0;
         idx   = 0;
         for (int i = 0; i < 8; i++) begin
            if (st[i] && !found) begin
               found = 1'b1;
               idx   = i;
            end
         end
         m_valid = found;
         m_freq  = found ? 12'(m_oct ? HI[idx] : LO[idx]) : 12'd0;
         up = st[8] & ~m_prev[0];
         dn = st[9] & ~m_prev[1];
         if (up && !dn) m_oct = 1'b1;
         else if (dn && !up) m_oct = 1'b0;
         m_prev = st[9:8];
         for (int b = 0; b < 10; b++) begin
            all1 = 1'b1;
            all0 = 1'b1;
            foreach (seen_win[j]) begin
               if (seen_win[j][b]) all0 = 1'b0;
               else all1 = 1'b0;
            end
            if (all1) m_stable[b] = 1'b1;
            else if (all0) m_stable[b] = 1'b0;
         end
      end
   endtask

   task automatic tick();
      logic [9:0] raw;
      logic       r;
      raw = {oct_dn, oct_up, key_in};
      r   = rst;
      @(posedge clk);
      #1;
      model_step(raw, r);
      chk("freq", freq, m_freq);
      chk("note_valid", {11'b0, note_valid}, {11'b0, m_valid});
      chk("octave", {11'b0, octave}, {11'b0, m_oct});
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   initial begin
      rst    = 1'b1;
      key_in = 8'hFF;
      oct_up = 1'b1;
      oct_dn = 1'b1;

      // Reset with every input high
      ticks(3);
      chk("rst_freq", freq, 12'd0);
      chk("rst_valid", {11'b0, note_valid}, 12'd0);
      chk("rst_octave", {11'b0, octave}, 12'd0);
      rst = 1'b0;
      ticks(6);
      chk("rst_release_e6", freq, 12'd0);
      tick();
      chk("rst_release_e7", freq, 12'd131);
      chk("rst_release_oct", {11'b0, octave}, 12'd0);

      // Bounce filter
      rst = 1'b1; key_in = '0; oct_up = 1'b0; oct_dn = 1'b0;
      ticks(2);
      rst = 1'b0;
      repeat (5) begin
         key_in[5] = 1'b1;
         ticks(3);
         key_in[5] = 1'b0;
         ticks(3);
         chk("bounce_silent", freq, 12'd0);
      end
      ticks(4);
      key_in[5] = 1'b1;
      ticks(6);
      chk("press_e6", freq, 12'd0);
      tick();
      chk("press_e7", freq, 12'd220);
      key_in[5] = 1'b0;
      ticks(6);
      chk("release_e6", freq, 12'd220);
      tick();
      chk("release_e7", freq, 12'd0);

      // Octave saturation with top C held
      key_in[7] = 1'b1;
      ticks(7);
      chk("c_hi_oct0", freq, 12'd262);
      for (int p = 0; p < 3; p++) begin
         oct_up = 1'b1;
         ticks(10);
         oct_up = 1'b0;
         ticks(10);
         chk("oct_up_freq", freq, 12'd523);
         chk("oct_up_oct", {11'b0, octave}, 12'd1);
      end
      for (int p = 0; p < 2; p++) begin
         oct_dn = 1'b1;
         ticks(10);
         oct_dn = 1'b0;
         ticks(10);
         chk("oct_dn_freq", freq, 12'd262);
         chk("oct_dn_oct", {11'b0, octave}, 12'd0);
      end

      // Simultaneous up/down cancels
      oct_up = 1'b1; oct_dn = 1'b1;
      ticks(10);
      chk("both_oct", {11'b0, octave}, 12'd0);
      oct_up = 1'b0; oct_dn = 1'b0;
      ticks(10);
      oct_up = 1'b1;
      ticks(10);
      chk("up_alone_oct", {11'b0, octave}, 12'd1);
      oct_up = 1'b0;
      ticks(10);

      // Priority in octave 1
      key_in = 8'b0001_0100;
      ticks(10);
      chk("prio_e", freq, 12'd330);
      key_in = 8'b0001_0000;
      for (int c = 0; c < 10; c++) begin
         tick();
         chk("prio_valid_held", {11'b0, note_valid}, 12'd1);
      end
      chk("prio_g", freq, 12'd392);

      // Reset mid-operation
      key_in = 8'b0000_0001;
      ticks(10);
      chk("mid_pre_freq", freq, 12'd262);
      rst = 1'b1;
      tick();
      chk("mid_rst_freq", freq, 12'd0);
      chk("mid_rst_oct", {11'b0, octave}, 12'd0);
      rst = 1'b0;
      ticks(6);
      chk("mid_e6", freq, 12'd0);
      tick();
      chk("mid_e7", freq, 12'd131);

      // Random button activity
      for (int c = 0; c < 3000; c++) begin
         int r;
         int b;
         r = int'($urandom_range(0, 9));
         if (r < 2) begin
            b = int'($urandom_range(0, 9));
            if (b < 8) key_in[b] = ~key_in[b];
            else if (b == 8) oct_up = ~oct_up;
            else oct_dn = ~oct_dn;
         end
         rst = ($urandom_range(0, 299) == 0);
         tick();
      end
      rst = 1'b0;
      ticks(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/note_selector.md
Name: note_selector

Overview:
- Producer of the 12-bit `freq` note bus that the tone path and the 7-segment note display consume.
- Turns raw push-button/switch inputs (8 note keys, octave up/down) into a registered note frequency in Hz.
- Each input is synchronised and debounced. The octave register saturates. Keys are resolved with fixed priority.
- `freq` = 0 means silence; the display decodes 0 as a dash.

Parameters:
- DEBOUNCE_CYCLES, 100000, consecutive clk cycles an input must hold a new level before it is accepted (1 ms at 100 MHz); legal minimum 2.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- key_in  input  8  raw note keys, asynchronous, active-high; bit0=C, 1=D, 2=E, 3=F, 4=G, 5=A, 6=B, 7=C of next octave
- oct_up_in  input  1  raw octave-up button, asynchronous, active-high
- oct_dn_in  input  1  raw octave-down button, asynchronous, active-high
- freq  output  12  selected note frequency in Hz, registered; 0 = no note
- note_valid  output  1  high when freq != 0, registered
- octave  output  1  current octave, registered; 0 = low, 1 = high

Behaviour:
- Reset:
  - Reset is synchronous and active-high: the clock is `clk`, the reset is `rst`, and everything is sampled on the rising edge of `clk`.
  - While rst=1: freq=0, note_valid=0, octave=0, all synchroniser flops=0, debounced states=0, debounce counters=0, edge-detect history=0.
  - Reset asserted mid-debounce discards any partial count.
- Synchroniser:
  - Each of the 10 raw inputs passes through a 2-flop synchroniser.
- Debounce (independent per input):
  - if sync == stable: cnt <= 0.
  - else if cnt == DEBOUNCE_CYCLES-1: stable <= sync, cnt <= 0.
  - else: cnt <= cnt+1.
  - Counter width is clog2(DEBOUNCE_CYCLES).
  - A bounce shorter than DEBOUNCE_CYCLES cycles never changes stable.
- Octave control:
  - Acts on the rising edge of debounced oct_up / oct_dn (stable & ~stable_prev).
  - Up edge: octave <= 1. Down edge: octave <= 0. Both saturate, so there is no wrap.
  - Up and down edges in the same cycle: octave unchanged.
  - Holding a button gives exactly one step.
- Note resolution:
  - Among debounced keys, the lowest set bit index wins.
  - No key set: freq <= 0.
  - Table for octave 0, bit0..7: 131, 147, 165, 175, 196, 220, 247, 262.
  - Table for octave 1, bit0..7: 262, 294, 330, 349, 392, 440, 494, 523.
- Output registers:
  - freq and note_valid are registered from the current debounced keys and the current octave register, with no extra pipeline.
  - A key change appears on freq on rising edge number DEBOUNCE_CYCLES+3, counting the first edge that samples the new raw level as edge 1.
  - An octave change appears on the octave output on edge DEBOUNCE_CYCLES+3 and on freq on edge DEBOUNCE_CYCLES+4.
  - Octave change while a key is held: freq moves to the new octave's value with no intermediate 0.
- Multiple keys:
  - Releasing the winning key while others remain held → freq follows the next lowest held key.
- Output constraint:
  - freq only ever takes one of the 15 table values or 0.

Test Plan:
- Reset, DEBOUNCE_CYCLES=4: assert rst for 3 cycles with all inputs high → freq=0, note_valid=0, octave=0. Release rst with inputs held → freq=131 (key bit0, octave 0) exactly 7 edges later.
- Debounce filter, N=4: toggle key_in[5] high for 3 cycles then low, repeated 5 times → freq stays 0. Hold key_in[5] high → freq=220 at edge 7; release → freq=0 at edge 7 after release.
- Octave saturation: pulse oct_up 3 times (each held 10 cycles) with key_in[7] held → freq 262 → 523, stays 523, octave=1. Pulse oct_dn twice → freq=262, octave=0.
- Simultaneous up/down: octave=0, press oct_up and oct_dn on the same cycle → octave remains 0. Release both, then press up alone → octave=1.
- Priority: hold keys bit2|bit4 in octave 1 → freq=330. Release bit2 → freq=392 with note_valid staying 1 throughout.
- Reset mid-operation: octave=1, key_in[0] held, freq=262. Assert rst for 1 cycle → next edge freq=0, octave=0. After release, freq=131 after 7 edges.
